// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter
//   Shares the two register-file write ports among four writeback sources
//   (ALU A, ALU B, memory, branch). Up to two ready results are granted per
//   cycle. A result that loses arbitration is parked in a one-entry skid
//   buffer for its source, and the source is held off by a registered stall
//   until that entry has been written.
//
//   Ports
//     clk, rst_n              core clock, asynchronous active-low reset
//     wb_alu_a .. wb_mem      source results (wb_line_t, valid when .ready)
//     wr_a, wr_b              registered register-file write ports
//     stall_<src>             registered back-pressure, high while a result
//                             from that source sits in its skid buffer
//
//   Build option
//     CORE_WB_AGING_EN        adds a per-source starvation counter. A source
//                             that has lost STARVE_LIMIT consecutive cycles
//                             becomes urgent and is ranked ahead of the
//                             non-urgent sources. Without it the ranking is
//                             pure fixed priority.

typedef struct packed {
  logic        ready;
  logic [4:0]  rd;
  logic [31:0] data;
} wb_line_t;

module core_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  input  wb_line_t wb_alu_a,
  input  wb_line_t wb_alu_b,
  input  wb_line_t wb_branch,
  input  wb_line_t wb_mem,
  output wb_line_t wr_a,
  output wb_line_t wr_b,
  output logic     stall_alu_a,
  output logic     stall_alu_b,
  output logic     stall_branch,
  output logic     stall_mem
);

  localparam int N = 4;

  // Index order is the fixed priority, highest first.
  wb_line_t [N-1:0] src_in;
  wb_line_t [N-1:0] cand;
  wb_line_t [N-1:0] pend_q, pend_d;
  wb_line_t         wr_a_q, wr_a_d;
  wb_line_t         wr_b_q, wr_b_d;
  logic [N-1:0]     urgent;
  logic [N-1:0]     grant;
  logic [1:0]       sel_a, sel_b;
  logic             vld_a, vld_b;

  assign src_in[0] = wb_alu_a;
  assign src_in[1] = wb_alu_b;
  assign src_in[2] = wb_mem;
  assign src_in[3] = wb_branch;

  // A parked entry always wins over the live input; while a source is
  // stalled its input lines are not looked at.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cand[i] = pend_q[i].ready ? pend_q[i] : src_in[i];
    end
  end

  // Two passes over the fixed order: urgent candidates first, then the
  // rest. The first two ready candidates found take port A then port B.
  always_comb begin
    vld_a = 1'b0;
    vld_b = 1'b0;
    sel_a = '0;
    sel_b = '0;
    grant = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i].ready && (urgent[i] == (pass == 0))) begin
          if (!vld_a) begin
            vld_a    = 1'b1;
            sel_a    = 2'(i);
            grant[i] = 1'b1;
          end else if (!vld_b) begin
            vld_b    = 1'b1;
            sel_b    = 2'(i);
            grant[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pend_d[i] = pend_q[i];
      if (pend_q[i].ready) begin
        if (grant[i]) pend_d[i] = '0;
      end else if (src_in[i].ready && !grant[i]) begin
        pend_d[i] = src_in[i];
      end
    end
    wr_a_d = vld_a ? cand[sel_a] : '0;
    wr_b_d = vld_b ? cand[sel_b] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      wr_a_q <= '0;
      wr_b_q <= '0;
    end else begin
      pend_q <= pend_d;
      wr_a_q <= wr_a_d;
      wr_b_q <= wr_b_d;
    end
  end

`ifdef CORE_WB_AGING_EN
  localparam int unsigned          AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0]     AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [N-1:0][AGE_W-1:0] age_q, age_d;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      urgent[i] = (age_q[i] == AGE_MAX);
    end
  end

  // Counts consecutive lost cycles; saturates at the limit so an urgent
  // source stays urgent until it is finally granted.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      age_d[i] = '0;
      if (cand[i].ready && !grant[i]) begin
        age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign urgent = '0;
`endif

  assign wr_a         = wr_a_q;
  assign wr_b         = wr_b_q;
  assign stall_alu_a  = pend_q[0].ready;
  assign stall_alu_b  = pend_q[1].ready;
  assign stall_mem    = pend_q[2].ready;
  assign stall_branch = pend_q[3].ready;

endmodule

// File: tb/tb_core_wb_arbiter.sv
module tb_core_wb_arbiter;

  typedef struct packed {
    logic        ready;
    logic [4:0]  rd;
    logic [31:0] data;
  } tb_line_t;

  localparam int LIMIT = 3;

  logic     clk;
  logic     rst_n;
  tb_line_t src [4];           // 0 alu_a, 1 alu_b, 2 mem, 3 branch
  tb_line_t wr_a, wr_b;
  logic     stall_alu_a, stall_alu_b, stall_branch, stall_mem;
  logic [3:0] st;

  assign st = {stall_branch, stall_mem, stall_alu_b, stall_alu_a};

  core_wb_arbiter #(.STARVE_LIMIT(LIMIT)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_alu_a     (src[0]),
    .wb_alu_b     (src[1]),
    .wb_branch    (src[3]),
    .wb_mem       (src[2]),
    .wr_a         (wr_a),
    .wr_b         (wr_b),
    .stall_alu_a  (stall_alu_a),
    .stall_alu_b  (stall_alu_b),
    .stall_branch (stall_branch),
    .stall_mem    (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one parked line and one lost-cycle count per source.
  tb_line_t   m_pend [4];
  int         m_age  [4];
  tb_line_t   exp_a, exp_b;
  logic [3:0] exp_st;
  int         cyc = 0;

  function automatic tb_line_t mk(input int rd, input logic [31:0] d);
    tb_line_t l;
    l.ready = 1'b1;
    l.rd    = 5'(rd);
    l.data  = d;
    return l;
  endfunction

  function automatic bit is_urgent(input int i);
`ifdef CORE_WB_AGING_EN
    return m_age[i] >= LIMIT;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = '0;
      m_age[i]  = 0;
    end
    exp_a  = '0;
    exp_b  = '0;
    exp_st = '0;
  endtask

  // Rank each ready candidate by (urgent ? 0 : 4) + index and take the two
  // smallest ranks.
  task automatic model_step();
    tb_line_t c [4];
    int first = -1, second = -1;
    int kf = 99, ks = 99, key;
    bit g;
    for (int i = 0; i < 4; i++) c[i] = m_pend[i].ready ? m_pend[i] : src[i];
    for (int i = 0; i < 4; i++) begin
      if (c[i].ready) begin
        key = i + (is_urgent(i) ? 0 : 4);
        if (key < kf) begin
          ks = kf; second = first; kf = key; first = i;
        end else if (key < ks) begin
          ks = key; second = i;
        end
      end
    end
    exp_a = (first  >= 0) ? c[first]  : '0;
    exp_b = (second >= 0) ? c[second] : '0;
    for (int i = 0; i < 4; i++) begin
      g = (i == first) || (i == second);
      if (c[i].ready && !g) m_age[i] = (m_age[i] < LIMIT) ? m_age[i] + 1 : LIMIT;
      else m_age[i] = 0;
      if (m_pend[i].ready) begin
        if (g) m_pend[i] = '0;
      end else if (src[i].ready && !g) begin
        m_pend[i] = src[i];
      end
      exp_st[i] = m_pend[i].ready;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk($sformatf("wr_a@%0d", cyc), 64'(wr_a), 64'(exp_a));
    chk($sformatf("wr_b@%0d", cyc), 64'(wr_b), 64'(exp_b));
    chk($sformatf("stall@%0d", cyc), 64'(st), 64'(exp_st));
  endtask

  // Sources that are not stalled go idle; stalled sources keep their line.
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) if (!m_pend[i].ready) src[i] = '0;
      cycle();
    end
  endtask

  tb_line_t la, lb, lm, lbr, ly, lm2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) src[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_a", 64'(wr_a), 64'd0);
    chk("reset_wr_b", 64'(wr_b), 64'd0);
    chk("reset_stall", 64'(st), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single source on alu_b
    src[1] = mk(7, 32'hB0B0_0001);
    cycle();
    chk("single_wr_a", 64'(wr_a), 64'(mk(7, 32'hB0B0_0001)));
    chk("single_wr_b_ready", 64'(wr_b.ready), 64'd0);
    chk("single_stall_alu_b", 64'(stall_alu_b), 64'd0);
    drain(1);

    // All four ready, then back-to-back handoff on mem
    la = mk(1, 32'hA000_0001); lb = mk(2, 32'hB000_0002);
    lm = mk(3, 32'hC000_0003); lbr = mk(4, 32'hD000_0004);
    ly = mk(5, 32'hEEEE_0005);
    src[0] = la; src[1] = lb; src[2] = lm; src[3] = lbr;
    cycle();
    chk("all4_t1_wr_a", 64'(wr_a), 64'(la));
    chk("all4_t1_wr_b", 64'(wr_b), 64'(lb));
    chk("all4_t1_stall_mem", 64'(stall_mem), 64'd1);
    chk("all4_t1_stall_branch", 64'(stall_branch), 64'd1);
    src[0] = '0; src[1] = '0;
    cycle();
    chk("all4_t2_wr_a", 64'(wr_a), 64'(lm));
    chk("all4_t2_wr_b", 64'(wr_b), 64'(lbr));
    chk("all4_t2_stalls", 64'(st), 64'd0);
    src[2] = ly; src[3] = '0;
    cycle();
    chk("b2b_wr_a", 64'(wr_a), 64'(ly));
    chk("b2b_wr_b_ready", 64'(wr_b.ready), 64'd0);
    src[2] = '0;
    cycle();
    chk("b2b_no_dup", 64'(wr_a.ready), 64'd0);

    // Skid hold: mem changes its line while stalled
    lm2 = mk(9, 32'h1234_5678);
    src[0] = mk(1, 32'h0A0A_0001); src[1] = mk(2, 32'h0B0B_0001); src[2] = lm2;
    cycle();
    src[2] = mk(10, 32'hDEAD_BEEF);
    src[0] = mk(1, 32'h0A0A_0002); src[1] = mk(2, 32'h0B0B_0002);
    cycle();
    chk("skid_stall_mem", 64'(stall_mem), 64'd1);
    src[0] = '0; src[1] = '0;
    cycle();
    chk("skid_wr_a", 64'(wr_a), 64'(lm2));
    drain(2);

    // Aging: both ALUs busy, branch ready at t0
    lbr = mk(11, 32'hBBBB_0000);
    src[0] = mk(1, 32'hAA00_0000); src[1] = mk(2, 32'hAB00_0000); src[3] = lbr;
    cycle();
    for (int k = 1; k <= 3; k++) begin
      src[0] = mk(1, 32'hAA00_0000 + 32'(k));
      if (!m_pend[1].ready) src[1] = mk(2, 32'hAB00_0000 + 32'(k));
      la = src[0];
      cycle();
`ifndef CORE_WB_AGING_EN
      chk($sformatf("noage_stall_branch_%0d", k), 64'(stall_branch), 64'd1);
`endif
    end
`ifdef CORE_WB_AGING_EN
    chk("age_wr_a_branch", 64'(wr_a), 64'(lbr));
    chk("age_wr_b_alu_a", 64'(wr_b), 64'(la));
    chk("age_stall_alu_b", 64'(stall_alu_b), 64'd1);
`endif
    drain(4);

    // Async reset mid-cycle with pending entries
    src[0] = mk(1, 32'h5000_0001); src[1] = mk(2, 32'h5000_0002);
    src[2] = mk(3, 32'h5000_0003); src[3] = mk(4, 32'h5000_0004);
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", 64'(st), 64'd0);
    chk("midrst_wr_a_ready", 64'(wr_a.ready), 64'd0);
    chk("midrst_wr_b_ready", 64'(wr_b.ready), 64'd0);
    for (int i = 0; i < 4; i++) src[i] = '0;
    model_reset();
    #2;
    rst_n = 1'b1;
    drain(3);

    // Randomized traffic at several load levels
    for (int phase = 0; phase < 4; phase++) begin
      int rate;
      rate = (phase == 0) ? 20 : (phase == 1) ? 50 : (phase == 2) ? 80 : 100;
      for (int k = 0; k < 500; k++) begin
        for (int i = 0; i < 4; i++) begin
          if (!m_pend[i].ready) begin
            if (int'($urandom_range(99)) < rate)
              src[i] = mk(int'($urandom_range(31)), $urandom);
            else
              src[i] = '0;
          end else if ($urandom_range(3) == 0) begin
            src[i].data = $urandom;
          end
        end
        cycle();
      end
      drain(8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_wb_arbiter.md
# core_wb_arbiter

Shares the two register-file write ports (`wr_a`, `wr_b`) among four writeback sources: ALU A, ALU B, branch unit and memory unit. Each cycle it grants up to two ready results by priority. Results that lose arbitration go into a one-entry skid buffer per source, and the source is back-pressured through a registered stall. The block sits between the execution units and the register file and replaces the combinational port selection in `core_writeback`.

## Interface
Parameters:
- `STARVE_LIMIT`, default 3: number of consecutive lost cycles before a source becomes urgent (only used with aging compiled in); legal range 1..15.

Ports:
- `clk` in 1: core clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wb_alu_a` in wb_line: ALU A result; valid when `.ready`.
- `wb_alu_b` in wb_line: ALU B result; valid when `.ready`.
- `wb_branch` in wb_line: branch unit result; valid when `.ready`.
- `wb_mem` in wb_line: memory unit result; valid when `.ready`.
- `wr_a` out wb_line: register-file write port A, registered.
- `wr_b` out wb_line: register-file write port B, registered.
- `stall_alu_a` out 1: ALU A must hold its result, registered.
- `stall_alu_b` out 1: ALU B must hold its result, registered.
- `stall_branch` out 1: branch unit must hold its result, registered.
- `stall_mem` out 1: memory unit must hold its result, registered.

## Operation
- Source index and fixed priority, highest first: 0 `alu_a`, 1 `alu_b`, 2 `mem`, 3 `branch`.
- The wb_line payload is opaque. Only `.ready` is interpreted.
- Per source i:
  - Pending buffer `P_i` (a wb_line), valid when `P_i.ready`.
  - `stall_i` equals `P_i.ready` (registered).
- Candidate `C_i`:
  - `C_i = P_i` when pending.
  - Otherwise `C_i = input_i`.
  - Input is ignored while `stall_i` is 1. The source holds its line, and the line is not sampled.
- Arbitration order:
  - Urgent candidates (aging) come before non-urgent ones.
  - Within each group, fixed priority applies.
  - The first granted candidate goes to `wr_a`, the second to `wr_b`.
  - If only one candidate is granted, it goes to `wr_a` and `wr_b.ready` is 0.
- Next-state rules per source:
  - Granted and pending: `P_i` cleared.
  - Ready but not granted and not pending: input captured into `P_i`.
  - Ready but not granted and already pending: `P_i` unchanged.
- Output ports load the granted lines. An unused port loads all-zero (`.ready` = 0).
- A result is never dropped or duplicated. Each accepted result appears exactly once on `wr_a` or `wr_b`.

## Timing
- Reset (asynchronous, immediate), all state cleared:
  - `wr_a` and `wr_b` all-zero.
  - All stalls 0.
  - All `P_i` invalid.
  - All age counters 0.
- Reset mid-operation discards pending results; sources must reissue them.
- Latency:
  - Input ready and granted at edge t: the line appears on a write port during cycle t+1.
  - Input captured at edge t: stall is high during cycle t+1.
- Stall handshake:
  - A source that sees `stall_i` = 0 at an edge with `.ready` = 1 has handed off its result.
  - A source that sees `stall_i` = 1 keeps its output stable.
- When a pending entry is granted at edge t, `stall_i` drops during cycle t+1. The source may present a new result in that cycle.
- All four ready at once, no pending:
  - t+1: `wr_a` = alu_a, `wr_b` = alu_b; `stall_mem` and `stall_branch` = 1.
  - t+2: `wr_a` = mem, `wr_b` = branch, provided the ALUs are idle.

## Configuration
- Macro `CORE_WB_AGING_EN`.
- With the macro defined:
  - Each source has a saturating age counter of width `$clog2(STARVE_LIMIT+1)`.
  - The counter increments on each edge where `C_i` is ready but not granted.
  - It clears on grant or when `C_i` is not ready.
  - A source with age equal to `STARVE_LIMIT` is urgent.
  - Worst-case wait for any source is bounded by `STARVE_LIMIT` + 2 cycles.
- Without the macro:
  - No counters; pure fixed priority.
  - `mem` and `branch` may starve indefinitely while both ALUs issue every cycle.

## Test plan
- Reset:
  - Stimulus: assert `rst_n` = 0 asynchronously mid-cycle while pending entries exist.
  - Response: all stalls 0 and `wr_a`/`wr_b` `.ready` = 0 immediately. After release, previously pending results never appear.
- Single source:
  - Stimulus: `wb_alu_b` ready with payload X for one cycle.
  - Response: next cycle `wr_a` = X, `wr_b.ready` = 0, `stall_alu_b` stays 0.
- All four ready for one cycle:
  - Response: t+1 `wr_a` = alu_a, `wr_b` = alu_b, `stall_mem` = `stall_branch` = 1.
  - Then t+2 `wr_a` = mem, `wr_b` = branch, all stalls 0.
- Skid hold:
  - Stimulus: `wb_mem` captured and the memory unit changes its payload while `stall_mem` = 1.
  - Response: the originally captured payload is written; the changed line is not sampled.
- Aging, with `CORE_WB_AGING_EN` and `STARVE_LIMIT` = 3:
  - Stimulus: both ALUs ready every cycle; `wb_branch` ready at edge t0.
  - With the macro: branch is granted at edge t3 and appears on `wr_a` at t4, with alu_a on `wr_b`. `stall_alu_b` = 1 at t4.
  - Without the macro: `stall_branch` stays 1 for as long as the ALUs are busy.
- Back-to-back handoff:
  - Stimulus: pending alu_a granted at edge t, and alu_a presents new result Y during t+1.
  - Response: Y is accepted and written at t+2, with no bubble and no duplicate.
